// File: rtl/swap_seq_pkg.sv
// Shared types for the swap sequencer: command opcodes, FSM states and the
// command legality check.
package swap_seq_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    CMD_SWAP    = 3'd0,
    CMD_ROTL    = 3'd1,
    CMD_ROTR    = 3'd2,
    CMD_REV     = 3'd3,
    CMD_RESTORE = 3'd4
  } cmd_op_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESTORE,
    DONE
  } state_e;

  // Range ops need lo <= hi; opcodes above RESTORE are undefined.
  function automatic logic is_legal(logic [OP_W-1:0] op, int unsigned lo, int unsigned hi);
    case (op)
      CMD_SWAP, CMD_RESTORE:     return 1'b1;
      CMD_ROTL, CMD_ROTR, CMD_REV: return lo <= hi;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/swap_sequencer_if.sv
// Command and mapper-strobe bundle between decode, the swap sequencer and the mapper.
interface swap_sequencer_if
  import swap_seq_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4
);
  localparam int unsigned REG_W = $clog2(NUM_REGS);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_op;
  logic [REG_W-1:0] cmd_lo;
  logic [REG_W-1:0] cmd_hi;
  logic             hold;
  logic             swap_valid;
  logic [REG_W-1:0] swap_a;
  logic [REG_W-1:0] swap_b;
  logic             map_reset;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output cmd_valid, cmd_op, cmd_lo, cmd_hi, hold,
    input  cmd_ready, swap_valid, swap_a, swap_b, map_reset, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_lo, cmd_hi, hold,
    output cmd_ready, swap_valid, swap_a, swap_b, map_reset, busy, done, err
  );

endinterface

// File: rtl/swap_sequencer.sv
// Expands one permutation command at a time into single-pair swap strobes
// (at most one per cycle) for the register mapper.
module swap_sequencer
  import swap_seq_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4
) (
  input  logic            clk,
  input  logic            reset,
  swap_sequencer_if.slave bus
);

  localparam int unsigned REG_W = $clog2(NUM_REGS);

  state_e           state_q;
  cmd_op_e          op_q;
  logic [REG_W-1:0] lo_q, hi_q;
  logic [REG_W-1:0] a_q, b_q;
  logic             cmd_ready_q, busy_q, done_q, err_q;

  logic             last_c;
  logic [REG_W-1:0] a_d, b_d;
  logic             swap_valid_c, map_reset_c;
  logic [REG_W-1:0] swap_a_c, swap_b_c;

  // Pair following the current one, and whether the current pair ends the command.
  always_comb begin
    last_c = 1'b1;
    a_d    = a_q;
    b_d    = b_q;
    case (op_q)
      CMD_ROTL: begin
        last_c = (b_q == hi_q);
        a_d    = a_q + REG_W'(1);
        b_d    = b_q + REG_W'(1);
      end
      CMD_ROTR: begin
        last_c = (a_q == lo_q);
        a_d    = a_q - REG_W'(1);
        b_d    = b_q - REG_W'(1);
      end
      CMD_REV: begin
        last_c = !((a_q + REG_W'(1)) < (b_q - REG_W'(1)));
        a_d    = a_q + REG_W'(1);
        b_d    = b_q - REG_W'(1);
      end
      default: ;
    endcase
  end

  // Mapper strobes follow hold combinationally: the mapper samples them on this same edge.
  always_comb begin
    swap_valid_c = 1'b0;
    swap_a_c     = '0;
    swap_b_c     = '0;
    map_reset_c  = 1'b0;
    if (state_q == ISSUE && !bus.hold) begin
      swap_valid_c = 1'b1;
      swap_a_c     = a_q;
      swap_b_c     = b_q;
    end
    if (state_q == RESTORE && !bus.hold) begin
      map_reset_c = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= CMD_SWAP;
      lo_q        <= '0;
      hi_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= cmd_op_e'(bus.cmd_op);
            lo_q        <= bus.cmd_lo;
            hi_q        <= bus.cmd_hi;
            a_q         <= (bus.cmd_op == CMD_ROTR) ? bus.cmd_hi - REG_W'(1) : bus.cmd_lo;
            b_q         <= (bus.cmd_op == CMD_ROTL) ? bus.cmd_lo + REG_W'(1) : bus.cmd_hi;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (!is_legal(bus.cmd_op, 32'(bus.cmd_lo), 32'(bus.cmd_hi))) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (bus.cmd_op == CMD_RESTORE) begin
              state_q <= RESTORE;
            end else if (bus.cmd_lo == bus.cmd_hi) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!bus.hold) begin
            a_q <= a_d;
            b_q <= b_d;
            if (last_c) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RESTORE: begin
          if (!bus.hold) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.swap_valid = swap_valid_c;
  assign bus.swap_a     = swap_a_c;
  assign bus.swap_b     = swap_b_c;
  assign bus.map_reset  = map_reset_c;

endmodule

// File: tb/tb_swap_sequencer.sv
// Self-checking bench: directed scenarios plus random commands against a
// permutation-level model of each command and a model of the mapper.
module tb_swap_sequencer;
  import swap_seq_pkg::*;

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned REG_W    = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  swap_sequencer_if #(.NUM_REGS(NUM_REGS)) bus ();
  swap_sequencer #(.NUM_REGS(NUM_REGS)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int obs_map[NUM_REGS];
  int exp_map[NUM_REGS];

  // Mapper model driven by the DUT strobes; it shares the sequencer reset.
  always @(posedge clk) begin
    if (reset || bus.map_reset) begin
      for (int k = 0; k < NUM_REGS; k++) obs_map[k] = k;
    end else if (bus.swap_valid) begin
      int t;
      t = obs_map[bus.swap_a];
      obs_map[bus.swap_a] = obs_map[bus.swap_b];
      obs_map[bus.swap_b] = t;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pack_map(input int m[NUM_REGS]);
    int r = 0;
    for (int k = 0; k < NUM_REGS; k++) r |= m[k] << (4 * k);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_identity();
    for (int k = 0; k < NUM_REGS; k++) exp_map[k] = k;
  endtask

  // Issue one command and follow it cycle by cycle against the model.
  task automatic run_cmd(input int op, input int lo, input int hi, input int hold_at, input bit rnd);
    int  pa[$];
    int  pb[$];
    int  old[NUM_REGS];
    int  i, j, c;
    bit  illegal, fin;
    illegal = (op > 4) || (op >= 1 && op <= 3 && lo > hi);
    old = exp_map;
    if (!illegal) begin
      case (op)
        0: begin
          if (lo != hi) begin pa.push_back(lo); pb.push_back(hi); end
          exp_map[lo] = old[hi];
          exp_map[hi] = old[lo];
        end
        1: begin
          for (int k = lo; k < hi; k++) begin pa.push_back(k); pb.push_back(k + 1); end
          for (int k = lo; k < hi; k++) exp_map[k] = old[k + 1];
          exp_map[hi] = old[lo];
        end
        2: begin
          for (int k = hi; k > lo; k--) begin pa.push_back(k - 1); pb.push_back(k); end
          for (int k = lo + 1; k <= hi; k++) exp_map[k] = old[k - 1];
          exp_map[lo] = old[hi];
        end
        3: begin
          i = lo; j = hi;
          while (i < j) begin pa.push_back(i); pb.push_back(j); i++; j--; end
          for (int k = lo; k <= hi; k++) exp_map[k] = old[lo + hi - k];
        end
        default: set_identity();
      endcase
    end

    check("idle_ready", int'(bus.cmd_ready), 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(op);
    bus.cmd_lo    = REG_W'(lo);
    bus.cmd_hi    = REG_W'(hi);
    bus.hold      = 1'b0;
    cyc();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'($urandom);
    bus.cmd_lo    = REG_W'($urandom);
    bus.cmd_hi    = REG_W'($urandom);
    c = 1;
    if (op == 4) begin
      fin = 1'b0;
      while (!fin && c < 64) begin
        bus.hold = (c == hold_at) || (rnd && c < 32 && $urandom_range(0, 3) == 0);
        #1;
        check("restore_strobe", int'(bus.map_reset), int'(!bus.hold));
        check("restore_no_swap", int'(bus.swap_valid), 0);
        check("restore_no_done", int'(bus.done), 0);
        fin = !bus.hold;
        cyc();
        c++;
      end
      if (!fin) check("restore_timeout", 0, 1);
    end else begin
      while (pa.size() > 0 && c < 64) begin
        bus.hold = (c == hold_at) || (rnd && c < 32 && $urandom_range(0, 3) == 0);
        #1;
        check("issue_busy", int'(bus.busy), 1);
        check("issue_no_done", int'(bus.done), 0);
        check("issue_not_ready", int'(bus.cmd_ready), 0);
        if (bus.hold) begin
          check("held_valid", int'(bus.swap_valid), 0);
          check("held_a", int'(bus.swap_a), 0);
          check("held_b", int'(bus.swap_b), 0);
        end else begin
          check("swap_valid", int'(bus.swap_valid), 1);
          check("swap_a", int'(bus.swap_a), pa.pop_front());
          check("swap_b", int'(bus.swap_b), pb.pop_front());
        end
        cyc();
        c++;
      end
      if (pa.size() > 0) check("issue_timeout", 0, 1);
    end
    bus.hold = 1'b0;
    #1;
    check("done_pulse", int'(bus.done), 1);
    check("err_flag", int'(bus.err), int'(illegal));
    check("done_no_swap", int'(bus.swap_valid), 0);
    check("done_no_restore", int'(bus.map_reset), 0);
    check("done_not_ready", int'(bus.cmd_ready), 0);
    cyc();
    check("after_done", int'(bus.done), 0);
    check("after_err", int'(bus.err), 0);
    check("after_ready", int'(bus.cmd_ready), 1);
    check("after_busy", int'(bus.busy), 0);
    check("mapping", pack_map(obs_map), pack_map(exp_map));
  endtask

  initial begin
    set_identity();
    reset         = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = '0;
    bus.cmd_lo    = '0;
    bus.cmd_hi    = '0;
    bus.hold      = 1'b0;
    cyc();
    cyc();
    check("rst_ready", int'(bus.cmd_ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_swap_valid", int'(bus.swap_valid), 0);
    check("rst_swap_a", int'(bus.swap_a), 0);
    check("rst_swap_b", int'(bus.swap_b), 0);
    check("rst_map_reset", int'(bus.map_reset), 0);
    reset = 1'b0;
    cyc();

    run_cmd(0, 1, 3, 0, 1'b0);
    check("swap13_map", pack_map(obs_map), 32'h1230);
    run_cmd(4, 0, 0, 0, 1'b0);
    run_cmd(1, 0, 3, 0, 1'b0);
    check("rotl_map", pack_map(obs_map), 32'h0321);
    run_cmd(4, 0, 0, 0, 1'b0);
    run_cmd(3, 0, 3, 2, 1'b0);
    check("rev_map", pack_map(obs_map), 32'h0123);
    run_cmd(2, 0, 3, 0, 1'b0);
    run_cmd(2, 2, 1, 0, 1'b0);
    run_cmd(6, 1, 2, 0, 1'b0);
    run_cmd(1, 2, 2, 0, 1'b0);
    run_cmd(4, 0, 0, 1, 1'b0);

    // Reset arrives while a rotate is mid-flight.
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(CMD_ROTL);
    bus.cmd_lo    = 2'd0;
    bus.cmd_hi    = 2'd3;
    cyc();
    bus.cmd_valid = 1'b0;
    check("mid_first_swap", int'(bus.swap_valid), 1);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("mid_no_swap", int'(bus.swap_valid), 0);
    check("mid_busy", int'(bus.busy), 0);
    check("mid_ready", int'(bus.cmd_ready), 1);
    check("mid_no_done", int'(bus.done), 0);
    check("mid_no_err", int'(bus.err), 0);
    cyc();
    check("mid_no_done_later", int'(bus.done), 0);
    check("mid_no_swap_later", int'(bus.swap_valid), 0);
    set_identity();
    check("mid_map", pack_map(obs_map), pack_map(exp_map));

    // RESTORE with a second command offered throughout.
    run_cmd(0, 2, 3, 0, 1'b0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 3'(CMD_RESTORE);
    cyc();
    bus.cmd_op = 3'(CMD_SWAP);
    bus.cmd_lo = 2'd0;
    bus.cmd_hi = 2'd1;
    check("hv_map_reset", int'(bus.map_reset), 1);
    check("hv_not_ready1", int'(bus.cmd_ready), 0);
    cyc();
    check("hv_done", int'(bus.done), 1);
    check("hv_map_reset_once", int'(bus.map_reset), 0);
    check("hv_not_ready2", int'(bus.cmd_ready), 0);
    check("hv_no_swap", int'(bus.swap_valid), 0);
    cyc();
    check("hv_ready", int'(bus.cmd_ready), 1);
    check("hv_idle_no_swap", int'(bus.swap_valid), 0);
    cyc();
    bus.cmd_valid = 1'b0;
    check("hv_second_valid", int'(bus.swap_valid), 1);
    check("hv_second_a", int'(bus.swap_a), 0);
    check("hv_second_b", int'(bus.swap_b), 1);
    cyc();
    check("hv_second_done", int'(bus.done), 1);
    cyc();
    set_identity();
    exp_map[0] = 1;
    exp_map[1] = 0;
    check("hv_map", pack_map(obs_map), pack_map(exp_map));

    for (int n = 0; n < 40; n++) begin
      run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
